// File: rtl/uart_dac_framer_pkg.sv
// Shared constants and parser state encoding
// for the UART-to-DAC sample framer.
package uart_dac_framer_pkg;

  localparam int DAC_W = 12;
  localparam logic [7:0] PKT_HDR = 8'hAA;

  typedef enum logic [1:0] {
    HUNT,
    GOT_HDR,
    GOT_HI,
    GOT_LO
  } pstate_t;

  // HI[7:4] is already known to be zero once we hold only the nibble
  function automatic logic chk_ok(
    input logic [3:0] hi_nib,
    input logic [7:0] lo,
    input logic [7:0] chk
  );
    return chk == ({4'h0, hi_nib} ^ lo);
  endfunction

endpackage

// File: rtl/uart_dac_framer_fifo.sv
// Synchronous show-ahead FIFO; a write into a full FIFO
// is still taken when a read happens in the same cycle.
module sync_fifo #(
  parameter int W  = 12,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr,
  input  logic [W-1:0]  din,
  input  logic          rd,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          push;
  logic          pop;

  assign full  = cnt[AW];
  assign empty = (cnt == '0);
  assign level = cnt;
  assign dout  = mem[rptr];
  assign pop   = rd & ~empty;
  assign push  = wr & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push}
                 - {{AW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/uart_dac_framer.sv
// Parses AA/HI/LO/CHK byte packets from the UART and
// paces the 12-bit samples out to the DAC902 bus.
module uart_dac_framer
  import uart_dac_framer_pkg::*;
#(
  parameter int DIV        = 1000,
  parameter int TIMEOUT    = 4095,
  parameter int DEPTH_LOG2 = 4,
  parameter logic [DAC_W-1:0] DAC_INIT = 12'h800
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rx_data,
  input  logic                  rdsig,
  input  logic                  clr,
  output logic [DAC_W-1:0]      dac_data,
  output logic                  dac_wr,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  pkt_err,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DW = $clog2(DIV);
  localparam int GW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [GW-1:0] TMO_MAX  = GW'(TIMEOUT);

  pstate_t          state;
  logic             rdsig_d;
  logic             stb;
  logic             tmo;
  logic [GW-1:0]    gap;
  logic [3:0]       hi_nib;
  logic [7:0]       lo;
  logic             wr_req;
  logic [DAC_W-1:0] sample;
  logic [DW-1:0]    div_cnt;
  logic             tick;
  logic             pop;
  logic             full;
  logic             empty;
  logic [DAC_W-1:0] head;
  logic             pkt_ev;
  logic             ovf_ev;
  logic             udf_ev;

  assign stb  = rdsig & ~rdsig_d;
  assign tmo  = (state != HUNT) && (gap == TMO_MAX);
  assign tick = (div_cnt == DIV_LAST);
  assign pop  = tick & ~empty;

  always_comb begin
    pkt_ev = tmo;
    if (stb && !tmo) begin
      unique case (1'b1)
        state == GOT_HDR: pkt_ev = (rx_data[7:4] != 4'h0);
        state == GOT_LO:  pkt_ev = !chk_ok(hi_nib, lo, rx_data);
        default:          pkt_ev = 1'b0;
      endcase
    end
  end

  assign ovf_ev = wr_req & full & ~pop;
  assign udf_ev = tick & empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdsig_d <= 1'b0;
      gap     <= '0;
    end else begin
      rdsig_d <= rdsig;
      if (stb)                gap <= '0;
      else if (gap != TMO_MAX) gap <= gap + 1'b1;
    end
  end

  // Timeout takes priority: a byte landing on that cycle is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= HUNT;
      hi_nib <= '0;
      lo     <= '0;
      wr_req <= 1'b0;
      sample <= '0;
    end else begin
      wr_req <= 1'b0;
      if (tmo) begin
        state <= HUNT;
      end else if (stb) begin
        unique case (state)
          HUNT: begin
            if (rx_data == PKT_HDR) state <= GOT_HDR;
          end
          GOT_HDR: begin
            hi_nib <= rx_data[3:0];
            state  <= (rx_data[7:4] != 4'h0) ? HUNT : GOT_HI;
          end
          GOT_HI: begin
            lo    <= rx_data;
            state <= GOT_LO;
          end
          GOT_LO: begin
            wr_req <= chk_ok(hi_nib, lo, rx_data);
            sample <= {hi_nib, lo};
            state  <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  sync_fifo #(
    .W  (DAC_W),
    .AW (DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr    (wr_req),
    .din   (sample),
    .rd    (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      dac_data <= DAC_INIT;
      dac_wr   <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      dac_wr  <= pop;
      if (pop) dac_data <= head;
    end
  end

  // A set event in the same cycle as clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_err <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      pkt_err <= pkt_ev | (pkt_err & ~clr);
      ovf     <= ovf_ev | (ovf & ~clr);
      udf     <= udf_ev | (udf & ~clr);
    end
  end

endmodule

// File: tb/tb_uart_dac_framer.sv
// Bench for uart_dac_framer: packet-level model plus
// directed packet sequences with literal expectations.
module tb_uart_dac_framer;

  localparam int DIV     = 1000;
  localparam int TIMEOUT = 4095;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rdsig = 1'b0;
  logic        clr = 1'b0;
  logic [11:0] dac_data;
  logic        dac_wr;
  logic [4:0]  level;
  logic        pkt_err;
  logic        ovf;
  logic        udf;

  uart_dac_framer #(
    .DIV        (DIV),
    .TIMEOUT    (TIMEOUT),
    .DEPTH_LOG2 (4),
    .DAC_INIT   (12'h800)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_data  (rx_data),
    .rdsig    (rdsig),
    .clr      (clr),
    .dac_data (dac_data),
    .dac_wr   (dac_wr),
    .level    (level),
    .pkt_err  (pkt_err),
    .ovf      (ovf),
    .udf      (udf)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Packet-level reference: byte events, sample queue, tick schedule
  int          cyc;
  int          pos;
  int          last_stb;
  logic [7:0]  mhi;
  logic [7:0]  mlo;
  logic [11:0] m_dac;
  logic [11:0] pend_s;
  logic [11:0] new_s;
  bit          m_prev, pend, new_pend;
  bit          byte_ev, tmo, perr_ev, ovf_ev, udf_ev;
  bit          m_wr, m_perr, m_ovf, m_udf;
  int          q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cyc = 0; pos = 0; last_stb = 0;
      m_prev = 0; pend = 0;
      m_dac = 12'h800; m_wr = 0;
      m_perr = 0; m_ovf = 0; m_udf = 0;
    end else begin
      cyc++;
      byte_ev = rdsig && !m_prev;
      m_prev = rdsig;
      tmo = (pos != 0) && (cyc - last_stb == TIMEOUT + 1);
      if (byte_ev) last_stb = cyc;
      perr_ev = tmo;
      new_pend = 0;
      if (tmo) pos = 0;
      else if (byte_ev) begin
        case (pos)
          0: if (rx_data == 8'hAA) pos = 1;
          1: begin
            if (rx_data[7:4] != 0) begin
              perr_ev = 1; pos = 0;
            end else begin
              mhi = rx_data; pos = 2;
            end
          end
          2: begin mlo = rx_data; pos = 3; end
          default: begin
            if (rx_data == (mhi ^ mlo)) begin
              new_pend = 1;
              new_s = {mhi[3:0], mlo};
            end else perr_ev = 1;
            pos = 0;
          end
        endcase
      end
      m_wr = 0;
      udf_ev = 0;
      if (cyc % DIV == 0) begin
        if (q.size() > 0) begin
          m_dac = 12'(q.pop_front());
          m_wr = 1;
        end else udf_ev = 1;
      end
      ovf_ev = 0;
      if (pend) begin
        if (q.size() < 16) q.push_back(int'(pend_s));
        else ovf_ev = 1;
      end
      pend = new_pend;
      pend_s = new_s;
      m_perr = perr_ev || (m_perr && !clr);
      m_ovf  = ovf_ev  || (m_ovf  && !clr);
      m_udf  = udf_ev  || (m_udf  && !clr);
    end
  end

  always @(negedge clk) begin
    check("dac_data", 32'(dac_data), 32'(m_dac));
    check("dac_wr",   32'(dac_wr),   32'(m_wr));
    check("level",    32'(level),    32'(q.size()));
    check("pkt_err",  32'(pkt_err),  32'(m_perr));
    check("ovf",      32'(ovf),      32'(m_ovf));
    check("udf",      32'(udf),      32'(m_udf));
  end

  task automatic send(input logic [7:0] b, input int hold = 1);
    @(negedge clk);
    rx_data = b;
    rdsig = 1'b1;
    repeat (hold) @(negedge clk);
    rdsig = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] hi,
                          input logic [7:0] lo,
                          input logic [7:0] ck);
    send(8'hAA);
    send(hi);
    send(lo);
    send(ck);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic align(input int ph);
    bit ok = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (cyc % DIV == ph) begin ok = 1; break; end
    end
    check("align_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_wr();
    bit got = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      @(negedge clk);
      if (dac_wr) begin got = 1; break; end
    end
    check("dac_wr_timeout", 32'(got), 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // reset state and first underflow tick
    @(negedge clk);
    check("rst_dac", 32'(dac_data), 32'h800);
    check("rst_wr", 32'(dac_wr), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_flags", 32'({pkt_err, ovf, udf}), 32'd0);
    align(0);
    check("first_udf", 32'(udf), 32'd1);
    check("idle_dac", 32'(dac_data), 32'h800);

    // valid packet, write lands one edge after CHK
    align(10);
    send_pkt(8'h0A, 8'hBC, 8'hB6);
    check("pre_wr_level", 32'(level), 32'd0);
    @(negedge clk);
    check("post_wr_level", 32'(level), 32'd1);
    wait_wr();
    check("abc_dac", 32'(dac_data), 32'hABC);
    check("abc_level", 32'(level), 32'd0);
    @(negedge clk);
    check("abc_wr_once", 32'(dac_wr), 32'd0);

    // bad checksum, then a valid packet with long rdsig
    align(10);
    pulse_clr();
    send_pkt(8'h0A, 8'hBC, 8'h00);
    @(negedge clk);
    check("chk_err", 32'(pkt_err), 32'd1);
    check("chk_level", 32'(level), 32'd0);
    send(8'hAA, 4);
    send(8'h01, 5);
    send(8'h23, 3);
    send(8'h22, 6);
    wait_wr();
    check("s123_dac", 32'(dac_data), 32'h123);

    // bad high nibble; trailing bytes ignored in HUNT
    align(10);
    pulse_clr();
    send(8'hAA);
    send(8'h1A);
    check("hi_err", 32'(pkt_err), 32'd1);
    send(8'hBC);
    send(8'hA6);
    repeat (3) @(negedge clk);
    check("hi_level", 32'(level), 32'd0);

    // timeout mid-packet, then recovery
    pulse_clr();
    send(8'hAA);
    send(8'h05);
    check("pre_tmo", 32'(pkt_err), 32'd0);
    repeat (TIMEOUT + 10) @(negedge clk);
    check("tmo_err", 32'(pkt_err), 32'd1);
    align(10);
    send_pkt(8'h05, 8'h55, 8'h50);
    wait_wr();
    check("s555_dac", 32'(dac_data), 32'h555);

    // overflow with the pacer between ticks, then drain
    align(5);
    pulse_clr();
    for (int i = 0; i < 18; i++) begin
      logic [7:0] lo;
      lo = 8'(i);
      send_pkt(8'h01, lo, 8'h01 ^ lo);
    end
    repeat (2) @(negedge clk);
    check("full_level", 32'(level), 32'd16);
    check("full_ovf", 32'(ovf), 32'd1);
    check("full_udf", 32'(udf), 32'd0);
    for (int k = 0; k < 16; k++) begin
      wait_wr();
      check("drain_order", 32'(dac_data), 32'(12'h100 + k));
    end
    check("drain_level", 32'(level), 32'd0);
    check("drain_udf", 32'(udf), 32'd0);
    align(0);
    check("after_udf", 32'(udf), 32'd1);
    pulse_clr();
    check("clr_flags", 32'({pkt_err, ovf, udf}), 32'd0);

    // async reset mid-packet loses FIFO and partial packet
    align(10);
    send_pkt(8'h07, 8'h77, 8'h70);
    send(8'hAA);
    send(8'h0A);
    @(negedge clk);
    check("pre_rst_level", 32'(level), 32'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_dac", 32'(dac_data), 32'h800);
    check("mid_rst_level", 32'(level), 32'd0);
    #2 rst_n = 1'b1;
    send(8'hBC);
    send(8'hB6);
    repeat (4) @(negedge clk);
    check("post_rst_level", 32'(level), 32'd0);
    check("post_rst_dac", 32'(dac_data), 32'h800);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
